// File: rtl/fsm_proto_pkg.sv
// Shared protocol constants for the 4-state ctrl/out controller interface.
package fsm_proto_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // ctrl words that select a non-default transition
  localparam int unsigned CTRL_S1_TO_S2 = 5;
  localparam int unsigned CTRL_S2_TO_S1 = 7;
  localparam int unsigned CTRL_S3_TO_S0 = 9;

  // Default ctrl when not steering; must not collide with 5, 7 or 9
  localparam int unsigned CTRL_IDLE_DEFAULT = 0;

  // Mealy out values of the controller
  localparam int unsigned OUT_S0_ANY   = 0;
  localparam int unsigned OUT_S1_TO_S2 = 2;
  localparam int unsigned OUT_S1_TO_S3 = 3;
  localparam int unsigned OUT_S2_ANY   = 9;
  localparam int unsigned OUT_S3_TO_S0 = 6;
  localparam int unsigned OUT_S3_STAY  = 11;

endpackage

// File: rtl/fsm_ref_model.sv
// Combinational model of the controller: (state, ctrl) -> (next_state, expected out).
module fsm_ref_model
  import fsm_proto_pkg::*;
#(
  parameter int W = 32,
  parameter int Y = 32
) (
  input  state_t         state,
  input  logic [W-1:0]   ctrl,
  output state_t         next_state,
  output logic [Y-1:0]   exp_out
);

  // Transition and Mealy output table of the controller
  always_comb begin
    next_state = S3;
    exp_out    = '0;
    case (state)
      S0: begin
        next_state = S1;
        exp_out    = Y'(OUT_S0_ANY);
      end
      S1: begin
        if (ctrl == W'(CTRL_S1_TO_S2)) begin
          next_state = S2;
          exp_out    = Y'(OUT_S1_TO_S2);
        end else begin
          next_state = S3;
          exp_out    = Y'(OUT_S1_TO_S3);
        end
      end
      S2: begin
        next_state = (ctrl == W'(CTRL_S2_TO_S1)) ? S1 : S3;
        exp_out    = Y'(OUT_S2_ANY);
      end
      S3: begin
        if (ctrl == W'(CTRL_S3_TO_S0)) begin
          next_state = S0;
          exp_out    = Y'(OUT_S3_TO_S0);
        end else begin
          next_state = S3;
          exp_out    = Y'(OUT_S3_STAY);
        end
      end
      default: begin
        next_state = S3;
        exp_out    = '0;
      end
    endcase
  end

endmodule

// File: rtl/fsm_path_driver.sv
// Initiator for the 4-state controller: accepts a target state from the host,
// steers the controller there along the shortest path, and checks its out
// against a shadow model every cycle.
module fsm_path_driver
  import fsm_proto_pkg::*;
#(
  parameter int             W         = 32,
  parameter int             Y         = 32,
  parameter logic [W-1:0]   CTRL_IDLE = W'(CTRL_IDLE_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_state,
  output logic [W-1:0]     ctrl,
  input  logic [Y-1:0]     fsm_out,
  output logic             done,
  output logic [1:0]       hops,
  output logic [1:0]       cur_state,
  output logic             err,
  output logic [1:0]       err_state
);

  state_t       r_state;
  state_t       r_tgt;
  state_t       r_err_state;
  logic         r_busy;
  logic         r_err;
  logic [1:0]   r_hops;

  state_t       w_next_state;
  logic [Y-1:0] w_exp_out;
  logic [W-1:0] w_ctrl;
  logic         w_steer;
  logic         w_arrive;
  logic         w_mismatch;
  logic         w_accept;

  // Shadow of the controller, driven with the same ctrl word it sees
  fsm_ref_model #(
    .W (W),
    .Y (Y)
  ) u_model (
    .state      (r_state),
    .ctrl       (w_ctrl),
    .next_state (w_next_state),
    .exp_out    (w_exp_out)
  );

  // Next hop selection: one ctrl word per cycle along the shortest path
  always_comb begin
    w_ctrl   = CTRL_IDLE;
    w_steer  = r_busy && !r_err && (r_state != r_tgt);
    w_arrive = r_busy && !r_err && (r_state == r_tgt);
    if (w_steer) begin
      case (r_tgt)
        S0: begin
          // From S1/S2 the idle word routes through S3 first
          if (r_state == S3) w_ctrl = W'(CTRL_S3_TO_S0);
        end
        S1: begin
          if (r_state == S2)      w_ctrl = W'(CTRL_S2_TO_S1);
          else if (r_state == S3) w_ctrl = W'(CTRL_S3_TO_S0);
        end
        S2: begin
          if (r_state == S1)      w_ctrl = W'(CTRL_S1_TO_S2);
          else if (r_state == S3) w_ctrl = W'(CTRL_S3_TO_S0);
        end
        default: w_ctrl = CTRL_IDLE;
      endcase
    end
  end

  // A mismatch in the arrival cycle suppresses done
  assign w_mismatch = !r_err && (fsm_out != w_exp_out);
  assign done       = w_arrive && !w_mismatch;
  assign req_ready  = !r_busy && !r_err;
  assign w_accept   = req_valid && req_ready;

  assign ctrl       = w_ctrl;
  assign hops       = r_hops;
  assign cur_state  = r_state;
  assign err        = r_err;
  assign err_state  = r_err_state;

  // Shadow state, request tracking, hop counter and sticky error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S0;
      r_tgt       <= S0;
      r_busy      <= 1'b0;
      r_hops      <= 2'd0;
      r_err       <= 1'b0;
      r_err_state <= S0;
    end else begin
      r_state <= w_next_state;
      if (w_mismatch) begin
        r_err       <= 1'b1;
        r_err_state <= r_state;
        r_busy      <= 1'b0;
      end else if (w_accept) begin
        r_tgt  <= state_t'(req_state);
        r_busy <= 1'b1;
        r_hops <= 2'd0;
      end else if (done) begin
        r_busy <= 1'b0;
      end else if (w_steer) begin
        r_hops <= r_hops + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_path_driver.sv
// Bench for fsm_path_driver: emulates the controller, checks per-cycle traces
// and scoreboards every done pulse.
module tb_fsm_path_driver;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_state;
  logic [31:0] ctrl;
  logic [31:0] fsm_out;
  logic        done;
  logic [1:0]  hops;
  logic [1:0]  cur_state;
  logic        err;
  logic [1:0]  err_state;

  // Controller emulation with an override for error injection
  logic [1:0]  c_state;
  logic [1:0]  c_next;
  logic [31:0] c_out;
  logic        force_en;
  logic [31:0] force_val;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0] hops;
    logic [1:0] state;
  } exp_t;

  exp_t sb_q[$];

  fsm_path_driver dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_state (req_state),
    .ctrl      (ctrl),
    .fsm_out   (fsm_out),
    .done      (done),
    .hops      (hops),
    .cur_state (cur_state),
    .err       (err),
    .err_state (err_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller transition table
  always_comb begin
    c_next = 2'd3;
    c_out  = 32'd0;
    case (c_state)
      2'd0: begin c_next = 2'd1; c_out = 32'd0; end
      2'd1: if (ctrl == 32'd5) begin c_next = 2'd2; c_out = 32'd2; end
            else begin c_next = 2'd3; c_out = 32'd3; end
      2'd2: begin c_next = (ctrl == 32'd7) ? 2'd1 : 2'd3; c_out = 32'd9; end
      default: if (ctrl == 32'd9) begin c_next = 2'd0; c_out = 32'd6; end
               else begin c_next = 2'd3; c_out = 32'd11; end
    endcase
  end

  // Controller state register, reset together with the driver
  always @(posedge clk) begin
    if (rst) c_state <= 2'd0;
    else     c_state <= c_next;
  end

  assign fsm_out = force_en ? force_val : c_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic trio(input string name, input logic [31:0] e_ctrl,
                      input logic [31:0] e_out, input logic [1:0] e_cur);
    chk({name, "_ctrl"}, ctrl, e_ctrl);
    chk({name, "_out"}, fsm_out, e_out);
    chk({name, "_cur"}, {30'd0, cur_state}, {30'd0, e_cur});
  endtask

  function automatic exp_t mk(input logic [1:0] h, input logic [1:0] s);
    exp_t e;
    e.hops  = h;
    e.state = s;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with hops=%0d state=%0d, required no done",
                 hops, cur_state);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("done: hops=%0d state=%0d (expected hops=%0d state=%0d)",
                 hops, cur_state, e.hops, e.state);
        chk("sb_hops", {30'd0, hops}, {30'd0, e.hops});
        chk("sb_state", {30'd0, cur_state}, {30'd0, e.state});
      end
    end
  end

  // Absolute time bound on the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_state = 2'd0;
    force_en  = 1'b0;
    force_val = 32'd0;

    // Reset state and idle drift S0 -> S1 -> S3
    repeat (2) @(negedge clk);
    trio("rst", 0, 0, 0);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_err_state", {30'd0, err_state}, 0);
    rst = 1'b0;
    $display("txn: reset released");
    @(negedge clk); trio("idle1", 0, 3, 1);
    @(negedge clk); trio("idle2", 0, 11, 3);
    @(negedge clk); trio("idle3", 0, 11, 3);
    chk("idle_err", {31'd0, err}, 0);

    // Parked S3 -> target S2 (3 hops)
    $display("txn: request S2 from S3");
    chk("t2_ready", {31'd0, req_ready}, 1);
    sb_q.push_back(mk(2'd3, 2'd2));
    req_valid = 1'b1; req_state = 2'd2;
    @(negedge clk); req_valid = 1'b0; req_state = 2'd3;
    trio("t2_h1", 9, 6, 3);
    chk("t2_busy_ready", {31'd0, req_ready}, 0);
    @(negedge clk); trio("t2_h2", 0, 0, 0);
    @(negedge clk); trio("t2_h3", 5, 2, 1);
    @(negedge clk); trio("t2_arr", 0, 9, 2);
    chk("t2_done", {31'd0, done}, 1);
    chk("t2_hops", {30'd0, hops}, 3);
    @(negedge clk); trio("t2_back", 0, 11, 3);
    chk("t2_done_clr", {31'd0, done}, 0);
    chk("t2_ready_again", {31'd0, req_ready}, 1);

    // Target S1 (2 hops), then S0 (1 hop) in the idle cycle after
    $display("txn: request S1 from S3");
    sb_q.push_back(mk(2'd2, 2'd1));
    req_valid = 1'b1; req_state = 2'd1;
    @(negedge clk); req_valid = 1'b0;
    trio("t3_h1", 9, 6, 3);
    @(negedge clk); trio("t3_h2", 0, 0, 0);
    @(negedge clk); trio("t3_arr", 0, 3, 1);
    chk("t3_done", {31'd0, done}, 1);
    chk("t3_hops", {30'd0, hops}, 2);
    chk("t3_ready_done", {31'd0, req_ready}, 0);
    @(negedge clk);
    chk("t3b_ready", {31'd0, req_ready}, 1);
    chk("t3b_cur", {30'd0, cur_state}, 3);
    $display("txn: request S0 from S3");
    sb_q.push_back(mk(2'd1, 2'd0));
    req_valid = 1'b1; req_state = 2'd0;
    @(negedge clk); req_valid = 1'b0;
    trio("t3b_h1", 9, 6, 3);
    @(negedge clk); trio("t3b_arr", 0, 0, 0);
    chk("t3b_done", {31'd0, done}, 1);
    chk("t3b_hops", {30'd0, hops}, 1);
    @(negedge clk); trio("t3b_drift1", 0, 3, 1);
    @(negedge clk); trio("t3b_drift2", 0, 11, 3);

    // 0-hop request: already parked in S3
    $display("txn: request S3 from S3");
    sb_q.push_back(mk(2'd0, 2'd3));
    req_valid = 1'b1; req_state = 2'd3;
    @(negedge clk); req_valid = 1'b0;
    trio("t4_arr", 0, 11, 3);
    chk("t4_done", {31'd0, done}, 1);
    chk("t4_hops", {30'd0, hops}, 0);
    @(negedge clk);
    chk("t4_ready", {31'd0, req_ready}, 1);

    // Reset mid-request while the shadow is in S0: no done may follow
    $display("txn: request S2 aborted by reset");
    req_valid = 1'b1; req_state = 2'd2;
    @(negedge clk); req_valid = 1'b0;
    trio("t6_h1", 9, 6, 3);
    @(negedge clk); trio("t6_h2", 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_cur", {30'd0, cur_state}, 0);
    chk("t6_ready", {31'd0, req_ready}, 1);
    chk("t6_done", {31'd0, done}, 0);
    chk("t6_ctrl", ctrl, 0);
    rst = 1'b0;
    @(negedge clk); trio("t6_drift1", 0, 3, 1);
    chk("t6_done1", {31'd0, done}, 0);
    @(negedge clk); trio("t6_drift2", 0, 11, 3);
    @(negedge clk);

    // Out mismatch while parked: sticky error until reset
    $display("txn: inject fsm_out=5 while parked");
    force_en = 1'b1; force_val = 32'd5;
    @(negedge clk);
    force_en = 1'b0;
    chk("t5_err", {31'd0, err}, 1);
    chk("t5_err_state", {30'd0, err_state}, 3);
    chk("t5_ready", {31'd0, req_ready}, 0);
    chk("t5_ctrl", ctrl, 0);
    req_valid = 1'b1; req_state = 2'd1;
    @(negedge clk);
    chk("t5_err_hold", {31'd0, err}, 1);
    chk("t5_ready_hold", {31'd0, req_ready}, 0);
    chk("t5_ctrl_hold", ctrl, 0);
    @(negedge clk);
    chk("t5_err_hold2", {31'd0, err}, 1);
    chk("t5_ctrl_hold2", ctrl, 0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_err", {31'd0, err}, 0);
    chk("t5_rst_err_state", {30'd0, err_state}, 0);
    chk("t5_rst_ready", {31'd0, req_ready}, 1);
    @(negedge clk);
    @(negedge clk);

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
